// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue/writeback stage in front of a combinational 19-bit ALU. Each instruction
//   takes three cycles (IDLE accept -> EXEC -> WB). Operands are read from an 8x19
//   register file, the ALU result is captured at the end of EXEC, and it is written
//   back at the end of WB. Divide-by-zero and illegal opcodes are handled locally.
//
//   Optional build macro ISSUE_DBG_PORT_EN adds a combinational register-file read
//   port (dbg_addr / dbg_data).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   instr_valid/ready   instruction handshake; instr = {op[3:0], rd, rs1, rs2, 6'reserved}
//   alu_r2, alu_r3      operand A / operand B to the ALU
//   alu_op              opcode to the ALU
//   alu_r1, alu_zero    ALU result and Zero output
//   wb_valid, wb_data   one-cycle retire pulse and the retiring value
//   zero_flag           Zero of the last retired legal instruction
//   div0_err            sticky divide-by-zero flag
//   illegal_err         sticky illegal-opcode flag
//   retired_cnt         retired-instruction counter (wraps)
//   dbg_addr, dbg_data  (ISSUE_DBG_PORT_EN only) register-file peek, R0 reads 0
module alu_issue_stage #(
  parameter int NREGS = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [18:0]      instr,
  output logic [18:0]      alu_r2,
  output logic [18:0]      alu_r3,
  output logic [3:0]       alu_op,
  input  logic [18:0]      alu_r1,
  input  logic             alu_zero,
  output logic             wb_valid,
  output logic [18:0]      wb_data,
  output logic             zero_flag,
  output logic             div0_err,
  output logic             illegal_err,
  output logic [CNT_W-1:0] retired_cnt
`ifdef ISSUE_DBG_PORT_EN
  ,
  input  logic [2:0]       dbg_addr,
  output logic [18:0]      dbg_data
`endif
);

  localparam int          DATA_W  = 19;
  localparam logic [3:0]  OP_DIV  = 4'd3;
  localparam logic [3:0]  OP_LAST = 4'd9;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [DATA_W-1:0] rf [NREGS];

  logic [2:0]        rd_p0;
  logic              legal_p1;
  logic              div0_p1;
  logic              zq_p1;

  logic              exec_legal;
  logic              exec_div0;

  // Reserved instruction bits carry no meaning.
  logic              unused_rsvd;
  assign unused_rsvd = ^instr[5:0];

  // Register 0 is hard-wired to zero on every read path.
  function automatic logic [DATA_W-1:0] rf_rd(input logic [2:0] a);
    return (a == 3'd0) ? '0 : rf[a];
  endfunction

  // Value retired by an instruction: zero for illegal opcodes, saturated
  // all-ones for divide-by-zero, otherwise the ALU result.
  function automatic logic [DATA_W-1:0] wb_result(input logic legal, input logic dz,
                                                  input logic [DATA_W-1:0] r);
    if (!legal) return '0;
    if (dz)     return '1;
    return r;
  endfunction

  assign exec_legal = (alu_op <= OP_LAST);
  assign exec_div0  = (alu_op == OP_DIV) && (alu_r3 == '0);

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        // Ready is suppressed while reset is held even though state is IDLE.
        instr_ready = !rst;
        accept      = instr_valid && !rst;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        wb_valid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      alu_op      <= '0;
      alu_r2      <= '0;
      alu_r3      <= '0;
      wb_data     <= '0;
      zero_flag   <= 1'b0;
      div0_err    <= 1'b0;
      illegal_err <= 1'b0;
      retired_cnt <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      // p0: issue - operands and opcode registered straight onto the ALU inputs
      if (accept) begin
        alu_op <= instr[18:15];
        alu_r2 <= rf_rd(instr[11:9]);
        alu_r3 <= rf_rd(instr[8:6]);
      end
      // p1: execute - wb_data doubles as the captured result register
      if (state == EXEC) wb_data <= wb_result(exec_legal, exec_div0, alu_r1);
      // p2: writeback
      if (state == WB) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
        if (legal_p1) begin
          if (rd_p0 != 3'd0) rf[rd_p0] <= wb_data;
          zero_flag <= zq_p1;
          if (div0_p1) div0_err <= 1'b1;
        end else begin
          illegal_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rd_p0 <= instr[14:12];
    if (state == EXEC) begin
      legal_p1 <= exec_legal;
      div0_p1  <= exec_legal && exec_div0;
      zq_p1    <= exec_legal && !exec_div0 && alu_zero;
    end
  end

`ifdef ISSUE_DBG_PORT_EN
  assign dbg_data = rf_rd(dbg_addr);
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized
// instructions, checked against a behavioural reference model of the register
// file, flags and counter. The bench also plays the role of the ALU.
module tb_alu_issue_stage;

  localparam logic [3:0] O_ADD = 4'd0, O_SUB = 4'd1, O_MUL = 4'd2, O_DIV = 4'd3,
                         O_INC = 4'd4, O_DEC = 4'd5, O_AND = 4'd6, O_OR  = 4'd7,
                         O_XOR = 4'd8, O_NOT = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [18:0] instr;
  logic [18:0] alu_r2, alu_r3, alu_r1;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        wb_valid;
  logic [18:0] wb_data;
  logic        zero_flag, div0_err, illegal_err;
  logic [15:0] retired_cnt;
`ifdef ISSUE_DBG_PORT_EN
  logic [2:0]  dbg_addr;
  logic [18:0] dbg_data;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [18:0] m_rf [8];
  logic        m_zf, m_div0, m_ill;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_op(alu_op),
    .alu_r1(alu_r1), .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_data(wb_data),
    .zero_flag(zero_flag), .div0_err(div0_err), .illegal_err(illegal_err),
    .retired_cnt(retired_cnt)
`ifdef ISSUE_DBG_PORT_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  // Behavioural ALU; divide-by-zero and illegal opcodes return garbage the DUT must ignore.
  function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [18:0] a,
                                        input logic [18:0] b);
    case (op)
      O_ADD:   return a + b;
      O_SUB:   return a - b;
      O_MUL:   return 19'(a * b);
      O_DIV:   return (b == 19'd0) ? 19'h2AAAA : a / b;
      O_INC:   return a + 19'd1;
      O_DEC:   return a - 19'd1;
      O_AND:   return a & b;
      O_OR:    return a | b;
      O_XOR:   return a ^ b;
      O_NOT:   return ~a;
      default: return 19'h01357;
    endcase
  endfunction

  always_comb begin
    alu_r1   = alu_f(alu_op, alu_r2, alu_r3);
    alu_zero = (alu_r1 == 19'd0);
  end

  function automatic logic [18:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    logic [5:0] junk;
    junk = 6'($urandom);
    return {op, rd, rs1, rs2, junk};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 19'd0;
    m_zf = 1'b0; m_div0 = 1'b0; m_ill = 1'b0; m_cnt = 16'd0;
  endtask

  // Retire one instruction in the model; returns the expected wb_data.
  task automatic model_exec(input logic [18:0] ins, output logic [18:0] res);
    logic [3:0]  op;
    logic [18:0] a, b;
    logic        dz;
    op = ins[18:15];
    a  = m_rf[ins[11:9]];
    b  = m_rf[ins[8:6]];
    if (op > 4'd9) begin
      res   = 19'd0;
      m_ill = 1'b1;
    end else begin
      dz  = (op == O_DIV) && (b == 19'd0);
      res = dz ? 19'h7FFFF : alu_f(op, a, b);
      if (ins[14:12] != 3'd0) m_rf[ins[14:12]] = res;
      m_zf = (res == 19'd0);
      if (dz) m_div0 = 1'b1;
    end
    m_cnt = m_cnt + 16'd1;
  endtask

  // Issue one instruction starting at a negedge in IDLE; ends at the negedge of the next IDLE.
  task automatic issue(input logic [18:0] ins, output logic [18:0] wbd);
    logic [18:0] exp;
    logic [18:0] a, b;
    a = m_rf[ins[11:9]];
    b = m_rf[ins[8:6]];
    check("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    instr       = 19'($urandom);
    check("ready_exec", instr_ready, 0);
    check("wbv_exec", wb_valid, 0);
    check("alu_op", alu_op, ins[18:15]);
    check("alu_r2", alu_r2, a);
    check("alu_r3", alu_r3, b);
    model_exec(ins, exp);
    @(posedge clk); @(negedge clk);
    check("ready_wb", instr_ready, 0);
    check("wbv_wb", wb_valid, 1);
    check("wb_data", wb_data, exp);
    wbd = wb_data;
    @(posedge clk); @(negedge clk);
    check("wbv_idle", wb_valid, 0);
    check("zero_flag", zero_flag, m_zf);
    check("div0_err", div0_err, m_div0);
    check("illegal_err", illegal_err, m_ill);
    check("retired_cnt", retired_cnt, m_cnt);
`ifdef ISSUE_DBG_PORT_EN
    dbg_addr = ins[14:12];
    #1 check("dbg_rd", dbg_data, m_rf[ins[14:12]]);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] wbd;
    int          acc;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 19'd0;
`ifdef ISSUE_DBG_PORT_EN
    dbg_addr    = 3'd0;
`endif
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ready", instr_ready, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_aluop", alu_op, 0);
    check("rst_r2", alu_r2, 0);
    check("rst_r3", alu_r3, 0);
    check("rst_flags", {zero_flag, div0_err, illegal_err}, 0);
    check("rst_cnt", retired_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", instr_ready, 1);

    // Preload R2=5 (INC), NOT/INC wrap to zero, then R1=10
    for (int i = 0; i < 5; i++) issue(mk(O_INC, 3'd2, 3'd2, 3'd0), wbd);
    check("r2_is5", wbd, 5);
    issue(mk(O_NOT, 3'd6, 3'd0, 3'd5), wbd);
    check("not0", wbd, 19'h7FFFF);
    issue(mk(O_INC, 3'd1, 3'd6, 3'd0), wbd);
    check("inc_wrap", wbd, 0);
    check("inc_wrap_zf", zero_flag, 1);
    issue(mk(O_ADD, 3'd1, 3'd2, 3'd2), wbd);
    check("r1_is10", wbd, 10);

    // ADD R3 = R1 + R2
    issue(mk(O_ADD, 3'd3, 3'd1, 3'd2), wbd);
    check("add15", wbd, 15);
    check("add15_zf", zero_flag, 0);

    // SUB to zero and negative wrap
    issue(mk(O_SUB, 3'd4, 3'd2, 3'd2), wbd);
    check("sub_zero", wbd, 0);
    check("sub_zero_zf", zero_flag, 1);
    issue(mk(O_SUB, 3'd4, 3'd2, 3'd1), wbd);
    check("sub_neg", wbd, 19'h7FFFB);

    // Divide by zero, then a legal op keeps the sticky flag; read RF[5] back
    issue(mk(O_DIV, 3'd5, 3'd1, 3'd0), wbd);
    check("div0_val", wbd, 19'h7FFFF);
    check("div0_flag", div0_err, 1);
    check("div0_zf", zero_flag, 0);
    issue(mk(O_ADD, 3'd7, 3'd5, 3'd0), wbd);
    check("rf5_sat", wbd, 19'h7FFFF);
    check("div0_sticky", div0_err, 1);
    issue(mk(O_DIV, 3'd6, 3'd1, 3'd2), wbd);
    check("div_ok", wbd, 2);

    // Illegal opcode leaves RF[3] and zero_flag alone; R0 writes are discarded
    issue(mk(O_SUB, 3'd4, 3'd2, 3'd2), wbd);
    issue(mk(4'b1100, 3'd3, 3'd1, 3'd2), wbd);
    check("ill_wbdata", wbd, 0);
    check("ill_flag", illegal_err, 1);
    check("ill_zf_kept", zero_flag, 1);
    issue(mk(O_XOR, 3'd0, 3'd3, 3'd0), wbd);
    check("rf3_kept", wbd, 15);
    issue(mk(O_ADD, 3'd7, 3'd0, 3'd0), wbd);
    check("r0_zero", wbd, 0);

    // instr_valid held high: accepts only in IDLE, every third cycle
    acc         = 0;
    instr_valid = 1'b1;
    instr       = mk(O_ADD, 3'd3, 3'd1, 3'd2);
    for (int c = 0; c < 9; c++) begin
      check("hold_ready", instr_ready, (c % 3 == 0));
      check("hold_wbv", wb_valid, (c % 3 == 2));
      if (instr_ready) acc++;
      @(posedge clk); @(negedge clk);
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) model_exec(instr, wbd);
    check("hold_accepts", acc, 3);
    check("hold_cnt", retired_cnt, m_cnt);

    // Randomized instructions against the model
    for (int i = 0; i < 40; i++)
      issue(mk(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom)), wbd);

    // Reset during EXEC of ADD R3
    instr_valid = 1'b1;
    instr       = mk(O_ADD, 3'd3, 3'd1, 3'd2);
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    rst         = 1'b1;
    #1;
    check("mid_rst_ready", instr_ready, 0);
    check("mid_rst_wbv", wb_valid, 0);
    check("mid_rst_outs", {alu_op, alu_r2, alu_r3, wb_data}, 0);
    check("mid_rst_flags", {zero_flag, div0_err, illegal_err}, 0);
    check("mid_rst_cnt", retired_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);
    check("post_rst_wbv", wb_valid, 0);
`ifdef ISSUE_DBG_PORT_EN
    dbg_addr = 3'd3;
    #1 check("dbg_rf3_rst", dbg_data, 0);
`endif
    issue(mk(O_ADD, 3'd7, 3'd3, 3'd0), wbd);
    check("rf3_after_rst", wbd, 0);
    check("cnt_after_rst", retired_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
